wash_sequencer: RTL and testbench

Parametrised program sequencer for the washing-machine controller. It runs a wash → N×rinse → spin programme with per-phase durations, a run/pause button, a door interlock that faults during spin, and a timed finish indication. Time advances only on a one-cycle `tick` enable from the divider. Outputs drive the motor, drain and buzzer logic and the display counters.

---
 rtl/wash_sequencer.sv | 151 +++++++++++++++
 tb/tb_wash_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer: wash, N rinses, spin, then a timed finish.
// Time advances only on the one-cycle tick enable; all outputs come from registered state.
module wash_sequencer #(
  parameter int TIME_W    = 8,
  parameter int RINSE_MAX = 3,
  parameter int FINISH_T  = 5,
  parameter int RC_W      = $clog2(RINSE_MAX + 1)
) (
  input  logic              cp,
  input  logic              rst,
  input  logic              tick,
  input  logic              run_btn,
  input  logic              door_open,
  input  logic [TIME_W-1:0] wash_t,
  input  logic [TIME_W-1:0] rinse_t,
  input  logic [TIME_W-1:0] spin_t,
  input  logic [RC_W-1:0]   rinse_cnt,
  output logic [2:0]        state,
  output logic [1:0]        phase,
  output logic [TIME_W-1:0] remain,
  output logic [RC_W-1:0]   rinse_left,
  output logic              motor_on,
  output logic              drain_on,
  output logic              alarm,
  output logic              buzzer,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] PH_WASH  = 2'd0;
  localparam logic [1:0] PH_RINSE = 2'd1;
  localparam logic [1:0] PH_SPIN  = 2'd2;

  logic [2:0]        state_q, state_d, st_cur;
  logic [1:0]        phase_q, phase_d, ph_cur;
  logic [TIME_W-1:0] remain_q, remain_d;
  logic [RC_W-1:0]   rinse_left_q, rinse_left_d;
  logic              done_q, done_d;

  function automatic logic [2:0] dec_state(input logic [2:0] s);
    return (s > S_FINISH) ? S_IDLE : s;
  endfunction

  function automatic logic [1:0] dec_phase(input logic [1:0] p);
    return (p == 2'd3) ? PH_SPIN : p;
  endfunction

  function automatic logic [RC_W-1:0] sat_rinse(input logic [RC_W-1:0] n);
    return (n > RC_W'(RINSE_MAX)) ? RC_W'(RINSE_MAX) : n;
  endfunction

  assign st_cur = dec_state(state_q);
  assign ph_cur = dec_phase(phase_q);

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_WASH;
      remain_q     <= '0;
      rinse_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      remain_q     <= remain_d;
      rinse_left_q <= rinse_left_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = st_cur;
    phase_d      = ph_cur;
    remain_d     = remain_q;
    rinse_left_d = rinse_left_q;
    done_d       = 1'b0;
    case (st_cur)
      S_IDLE: begin
        if (!run_btn) state_d = S_SET;
      end
      S_SET: begin
        phase_d  = PH_WASH;
        remain_d = wash_t;
        if (run_btn && !door_open) begin
          state_d      = S_RUN;
          rinse_left_d = sat_rinse(rinse_cnt);
        end
      end
      S_RUN: begin
        // Pause/door/error transitions swallow a coincident tick.
        if (!run_btn)                            state_d = S_PAUSE;
        else if (door_open && ph_cur == PH_SPIN) state_d = S_ERROR;
        else if (door_open)                      state_d = S_PAUSE;
        else if (tick) begin
          if (remain_q > TIME_W'(1)) begin
            remain_d = remain_q - TIME_W'(1);
          end else if (ph_cur == PH_SPIN) begin
            state_d  = S_FINISH;
            remain_d = TIME_W'(FINISH_T);
            done_d   = 1'b1;
          end else if (rinse_left_q != '0) begin
            phase_d      = PH_RINSE;
            remain_d     = rinse_t;
            rinse_left_d = rinse_left_q - RC_W'(1);
          end else begin
            phase_d  = PH_SPIN;
            remain_d = spin_t;
          end
        end
      end
      S_PAUSE: begin
        if (run_btn && !door_open) state_d = S_RUN;
      end
      S_ERROR: begin
        if (!door_open) state_d = run_btn ? S_RUN : S_PAUSE;
      end
      S_FINISH: begin
        if (!run_btn) begin
          state_d = S_SET;
        end else if (tick) begin
          if (remain_q <= TIME_W'(1)) begin
            state_d  = S_IDLE;
            remain_d = '0;
          end else begin
            remain_d = remain_q - TIME_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state      = st_cur;
    phase      = ph_cur;
    remain     = remain_q;
    rinse_left = rinse_left_q;
    motor_on   = (st_cur == S_RUN);
    drain_on   = (st_cur == S_RUN) && (ph_cur == PH_SPIN);
    alarm      = (st_cur == S_ERROR);
    buzzer     = (st_cur == S_FINISH);
    done       = done_q;
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: each driven cycle pushes its expected outputs to a
// scoreboard queue, which is popped and compared once the DUT has updated.
module tb_wash_sequencer;

  localparam int TIME_W    = 8;
  localparam int RINSE_MAX = 3;
  localparam int FINISH_T  = 5;
  localparam int RC_W      = 3;

  logic              cp;
  logic              rst;
  logic              tick;
  logic              run_btn;
  logic              door_open;
  logic [TIME_W-1:0] wash_t;
  logic [TIME_W-1:0] rinse_t;
  logic [TIME_W-1:0] spin_t;
  logic [RC_W-1:0]   rinse_cnt;
  logic [2:0]        state;
  logic [1:0]        phase;
  logic [TIME_W-1:0] remain;
  logic [RC_W-1:0]   rinse_left;
  logic              motor_on;
  logic              drain_on;
  logic              alarm;
  logic              buzzer;
  logic              done;

  wash_sequencer #(
    .TIME_W(TIME_W), .RINSE_MAX(RINSE_MAX), .FINISH_T(FINISH_T), .RC_W(RC_W)
  ) dut (
    .cp(cp), .rst(rst), .tick(tick), .run_btn(run_btn), .door_open(door_open),
    .wash_t(wash_t), .rinse_t(rinse_t), .spin_t(spin_t), .rinse_cnt(rinse_cnt),
    .state(state), .phase(phase), .remain(remain), .rinse_left(rinse_left),
    .motor_on(motor_on), .drain_on(drain_on), .alarm(alarm), .buzzer(buzzer),
    .done(done)
  );

  typedef struct {
    int step;
    int st;
    int ph;
    int rem;
    int rl;
    int dn;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, queue expectations (-1 = don't care), compare after the edge.
  task automatic drive(input int r, input int t, input int rn, input int d,
                       input int st, input int ph, input int rem, input int rl,
                       input int dn);
    exp_t e;
    rst       = (r != 0);
    tick      = (t != 0);
    run_btn   = (rn != 0);
    door_open = (d != 0);
    step++;
    e.step = step; e.st = st; e.ph = ph; e.rem = rem; e.rl = rl; e.dn = dn;
    sb.push_back(e);
    @(posedge cp);
    @(negedge cp);
    if (sb.size() == 0) begin
      chk($sformatf("s%0d_sb_empty", step), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("s%0d_state", e.step), int'(state), e.st);
      if (e.ph >= 0)  chk($sformatf("s%0d_phase", e.step), int'(phase), e.ph);
      if (e.rem >= 0) chk($sformatf("s%0d_remain", e.step), int'(remain), e.rem);
      if (e.rl >= 0)  chk($sformatf("s%0d_rinse_left", e.step), int'(rinse_left), e.rl);
      chk($sformatf("s%0d_done", e.step), int'(done), e.dn);
      chk($sformatf("s%0d_motor", e.step), int'(motor_on), int'(e.st == 2));
      chk($sformatf("s%0d_alarm", e.step), int'(alarm), int'(e.st == 4));
      chk($sformatf("s%0d_buzzer", e.step), int'(buzzer), int'(e.st == 5));
      if (e.ph >= 0)
        chk($sformatf("s%0d_drain", e.step), int'(drain_on), int'(e.st == 2 && e.ph == 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; run_btn = 1'b1; door_open = 1'b0;
    wash_t = 8'd3; rinse_t = 8'd2; spin_t = 8'd2; rinse_cnt = 3'd2;
    @(negedge cp);

    // Reset state, then full programme: WASHx3, RINSEx2, RINSEx2, SPINx2 = 9 ticks.
    drive(1,0,1,0, 0,0,0,0,0);
    drive(1,1,1,0, 0,0,0,0,0);
    drive(0,1,1,0, 0,0,0,0,0);
    drive(0,0,0,0, 1,0,0,0,0);
    drive(0,0,0,0, 1,0,3,0,0);
    drive(0,0,1,0, 2,0,3,2,0);
    drive(0,0,1,0, 2,0,3,2,0);
    drive(0,1,1,0, 2,0,2,2,0);
    drive(0,1,1,0, 2,0,1,2,0);
    drive(0,1,1,0, 2,1,2,1,0);
    drive(0,1,1,0, 2,1,1,1,0);
    drive(0,1,1,0, 2,1,2,0,0);
    drive(0,1,1,0, 2,1,1,0,0);
    drive(0,1,1,0, 2,2,2,0,0);
    drive(0,1,1,0, 2,2,1,0,0);
    drive(0,1,1,0, 5,2,5,0,1);
    drive(0,0,1,0, 5,2,5,0,0);
    drive(0,1,1,0, 5,2,4,0,0);
    drive(0,1,1,0, 5,2,3,0,0);
    drive(0,1,1,0, 5,2,2,0,0);
    drive(0,1,1,0, 5,2,1,0,0);
    drive(0,1,1,0, 0,2,0,0,0);

    // Pause/resume with a tick on the run_btn fall edge, then door in RINSE.
    rinse_cnt = 3'd1;
    drive(0,0,0,0, 1,-1,-1,0,0);
    drive(0,0,0,0, 1,0,3,0,0);
    drive(0,0,1,0, 2,0,3,1,0);
    drive(0,1,1,0, 2,0,2,1,0);
    drive(0,1,0,0, 3,0,2,1,0);
    for (int i = 0; i < 4; i++) drive(0,1,0,0, 3,0,2,1,0);
    drive(0,0,1,0, 2,0,2,1,0);
    drive(0,1,1,0, 2,0,1,1,0);
    drive(0,1,1,0, 2,1,2,0,0);
    drive(0,1,1,1, 3,1,2,0,0);
    drive(0,0,1,1, 3,1,2,0,0);
    drive(0,0,1,0, 2,1,2,0,0);
    drive(0,1,1,0, 2,1,1,0,0);
    drive(0,1,1,0, 2,2,2,0,0);

    // Spin interlock: ERROR, recover to RUN, then again recovering to PAUSE.
    drive(0,1,1,1, 4,2,2,0,0);
    drive(0,1,1,1, 4,2,2,0,0);
    drive(0,0,1,0, 2,2,2,0,0);
    drive(0,1,1,0, 2,2,1,0,0);
    drive(0,0,1,1, 4,2,1,0,0);
    drive(0,0,0,0, 3,2,1,0,0);
    drive(0,0,1,0, 2,2,1,0,0);
    drive(0,1,1,0, 5,2,5,0,1);

    // Finish acknowledge, then rinse_cnt=0 with wash_t=0.
    wash_t = 8'd0; spin_t = 8'd1; rinse_cnt = 3'd0;
    drive(0,0,0,0, 1,-1,-1,0,0);
    drive(0,0,0,0, 1,0,0,0,0);
    drive(0,0,1,0, 2,0,0,0,0);
    drive(0,1,1,0, 2,2,1,0,0);
    drive(0,1,1,0, 5,2,5,0,1);

    // rinse_cnt=7 saturates to 3 rinses.
    wash_t = 8'd1; rinse_t = 8'd1; rinse_cnt = 3'd7;
    drive(0,0,0,0, 1,-1,-1,0,0);
    drive(0,0,0,0, 1,0,1,0,0);
    drive(0,0,1,0, 2,0,1,3,0);
    drive(0,1,1,0, 2,1,1,2,0);
    drive(0,1,1,0, 2,1,1,1,0);
    drive(0,1,1,0, 2,1,1,0,0);
    drive(0,1,1,0, 2,2,1,0,0);
    drive(0,1,1,0, 5,2,5,0,1);

    // Reset mid-RINSE.
    rinse_t = 8'd3; rinse_cnt = 3'd2;
    drive(0,0,0,0, 1,-1,-1,0,0);
    drive(0,0,0,0, 1,0,1,0,0);
    drive(0,0,1,0, 2,0,1,2,0);
    drive(0,1,1,0, 2,1,3,1,0);
    drive(0,1,1,0, 2,1,2,1,0);
    drive(1,1,1,0, 0,0,0,0,0);
    drive(0,1,1,0, 0,0,0,0,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
